fetch_queue: RTL

Parametrised instruction-fetch front end that replaces the fixed two-stage address/data fetch pair of the pipelined CPU. It issues sequential fetch addresses to a fixed-latency synchronous instruction memory port, tracks in-flight requests, and buffers returned words with their PCs in a DEPTH-entry queue that decode drains with a ready/valid handshake. Branch redirects squash the queue and all in-flight requests with zero-bubble re-issue. It sits between instruction memory read port 0 and decode.

---
 rtl/fetch_queue_pkg.sv | 19 +
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue_fifo.sv | 68 ++++++
 rtl/fetch_queue.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch front end: fetch granule,
// the default {pc, instr} queue entry and a parameter legality helper.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned DEFAULT_XLEN = 32;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [DEFAULT_XLEN-1:0] instr;
    } fetch_entry_t;

    // DEPTH must be a power of two of at least 2; memory latency at least 1.
    function automatic bit fetch_params_legal(input int unsigned depth,
                                              input int unsigned mem_lat);
        return (depth >= 2) && ((depth & (depth - 1)) == 0) && (mem_lat >= 1);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction memory read port plus the decode-side
// ready/valid handshake. master = fetch_queue, slave = memory/decode side.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic            mem_ren;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic            out_valid;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic            out_ready;

    modport master (
        output mem_ren, mem_addr, out_valid, out_instr, out_pc,
        input  mem_data, out_ready
    );

    modport slave (
        input  mem_ren, mem_addr, out_valid, out_instr, out_pc,
        output mem_data, out_ready
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch entries. Pointers carry an extra
// wrap bit so full and empty are distinguishable; clear wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic                   empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0] wptr_q, wptr_d;
    logic [PTR_W:0] rptr_q, rptr_d;
    entry_t         mem_q [DEPTH];
    entry_t         mem_d [DEPTH];
    logic           full;
    logic           push_en;
    logic           pop_en;

    // Status flags, head read and pointer/storage next state
    always_comb begin
        empty     = (wptr_q == rptr_q);
        full      = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                    (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
        occupancy = wptr_q - rptr_q;
        head      = mem_q[rptr_q[PTR_W-1:0]];
        push_en   = push && (!full || pop);
        pop_en    = pop && (!empty || push);
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        mem_d     = mem_q;
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_en) begin
                mem_d[wptr_q[PTR_W-1:0]] = push_data;
                wptr_d = wptr_q + PTR_ONE;
            end
            if (pop_en) begin
                rptr_d = rptr_q + PTR_ONE;
            end
        end
    end

    // Pointer and storage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential address issue to a fixed-latency
// memory, in-flight tracking, and a credit-limited queue drained by decode.
// Optional macro FETCH_QUEUE_BYPASS_EN: an empty queue forwards the
// returning word to out_* combinationally in its return cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter int unsigned     MEM_LAT  = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            halt,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_tgt,
    fetch_queue_if.master   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + MEM_LAT + 2) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    if (!fetch_params_legal(DEPTH, MEM_LAT)) begin : g_bad_cfg
        $error("fetch_queue: DEPTH must be a power of two >= 2 and MEM_LAT >= 1");
    end

    logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
    logic [MEM_LAT-1:0] trk_valid_q, trk_valid_d;
    logic [XLEN-1:0]    trk_pc_q [MEM_LAT];
    logic [XLEN-1:0]    trk_pc_d [MEM_LAT];

    logic               tail_valid;
    entry_t             ret_entry;
    entry_t             fifo_head;
    logic [PTR_W:0]     fifo_occ;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_clear;
    logic               deq;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   used;
    logic               credit_ok;

    // Head selection, decode handshake and queue push/pop control
    always_comb begin
        tail_valid    = trk_valid_q[MEM_LAT-1];
        ret_entry     = '{pc: trk_pc_q[MEM_LAT-1], instr: bus.mem_data};
        bus.out_valid = 1'b0;
        bus.out_pc    = '0;
        bus.out_instr = '0;
        if (!fifo_empty) begin
            bus.out_valid = 1'b1;
            bus.out_pc    = fifo_head.pc;
            bus.out_instr = fifo_head.instr;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (tail_valid) begin
            bus.out_valid = 1'b1;
            bus.out_pc    = ret_entry.pc;
            bus.out_instr = ret_entry.instr;
        end
`endif
        if (rst || redirect) begin
            bus.out_valid = 1'b0;
            bus.out_pc    = '0;
            bus.out_instr = '0;
        end
        deq        = bus.out_valid && bus.out_ready;
        fifo_clear = rst || redirect;
        fifo_push  = tail_valid && !rst && !redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
        // A bypassed word consumed this cycle never enters the queue.
        if (fifo_empty && deq) begin
            fifo_push = 1'b0;
        end
`endif
        fifo_pop   = deq && !fifo_empty;
    end

    // Credit check, address issue and in-flight tracker next state
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < MEM_LAT; i++) begin
            inflight = inflight + CNT_W'(trk_valid_q[i]);
        end
        used      = CNT_W'(fifo_occ) + inflight;
        credit_ok = used < (CNT_W'(DEPTH) + CNT_W'(deq));

        trk_valid_d    = '0;
        trk_pc_d       = trk_pc_q;
        for (int unsigned i = 1; i < MEM_LAT; i++) begin
            trk_valid_d[i] = trk_valid_q[i-1];
            trk_pc_d[i]    = trk_pc_q[i-1];
        end
        fetch_pc_d   = fetch_pc_q;
        bus.mem_ren  = 1'b0;
        bus.mem_addr = fetch_pc_q;

        if (rst) begin
            bus.mem_addr = RESET_PC;
        end else if (redirect) begin
            // Squash everything in flight; the target issues in the same cycle.
            trk_valid_d = '0;
            if (!halt) begin
                bus.mem_ren    = 1'b1;
                bus.mem_addr   = redirect_tgt;
                trk_valid_d[0] = 1'b1;
                trk_pc_d[0]    = redirect_tgt;
                fetch_pc_d     = redirect_tgt + XLEN'(INSTR_BYTES);
            end else begin
                fetch_pc_d = redirect_tgt;
            end
        end else if (!halt && credit_ok) begin
            bus.mem_ren    = 1'b1;
            trk_valid_d[0] = 1'b1;
            trk_pc_d[0]    = fetch_pc_q;
            fetch_pc_d     = fetch_pc_q + XLEN'(INSTR_BYTES);
        end
    end

    // Fetch PC and tracker registers
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            trk_valid_q <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            trk_valid_q <= trk_valid_d;
        end
        trk_pc_q <= trk_pc_d;
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (fifo_clear),
        .push      (fifo_push),
        .push_data (ret_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .occupancy (fifo_occ),
        .empty     (fifo_empty)
    );

endmodule
